// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   In-order instruction fetch queue between a fetch PC generator, an instruction memory with
//   decoupled request/response handshakes, and the decode stage. Each entry is allocated when a
//   memory request is accepted and filled when its in-order response returns. A redirect flushes
//   the queue and turns any still-outstanding responses into discards (drop_cnt).
//
//   Optional feature macro: IFQ_ALIGN_CHECK_EN
//     defined   -> a redirect to a non-word-aligned target raises the sticky fetch_fault flag
//                  and halts requests until reset or an aligned redirect.
//     undefined -> redirect_pc[1:0] is ignored and fetch_fault is tied to 0.
//
// Parameters
//   PC_WIDTH  program counter width in bits (>= 8)
//   RESET_PC  fetch address after reset (word aligned)
//   DEPTH     queue entries (power of two, >= 2)
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   redirect_valid   redirect request; flushes queue, retargets fetch_pc
//   redirect_pc      redirect target byte address
//   imem_req_valid   fetch request to instruction memory
//   imem_req_ready   memory accepts the request this cycle
//   imem_addr        word address of the request (fetch_pc >> 2)
//   imem_resp_valid  in-order memory response
//   imem_resp_data   fetched instruction
//   out_valid        head instruction available to decode
//   out_ready        decode accepts the head instruction
//   out_instr        head instruction
//   out_pc           byte address of out_instr
//   fetch_fault      sticky misaligned-redirect flag
module instruction_fetch_queue #(
    parameter int unsigned          PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-3:0] imem_addr,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                fetch_fault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Discards accumulate across back-to-back redirects while the memory still holds
    // responses; the extra headroom covers memories with many requests in flight.
    localparam int unsigned DROP_W = CNT_W + 6;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] pc_q    [DEPTH];
    logic [31:0]         instr_q [DEPTH];
    logic [DEPTH-1:0]    filled_q, filled_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W-1:0]    fill_q, fill_d;     // oldest allocated but unfilled entry
    logic [CNT_W-1:0]    count_q, count_d;   // allocated entries
    logic [CNT_W-1:0]    pending_q, pending_d; // allocated entries still waiting for data
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                accept;
    logic                resp_fill;
    logic                resp_drop;
    logic                pop;
    logic [PC_WIDTH-1:0] redirect_target;

    assign redirect_target = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    assign imem_req_valid = !reset && !redirect_valid && !fetch_fault &&
                            (count_q < CNT_W'(DEPTH));
    assign imem_addr      = fetch_pc_q[PC_WIDTH-1:2];

    assign accept    = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are ignored.
    assign resp_fill = imem_resp_valid && (drop_q == '0) && (pending_q != '0);
    assign resp_drop = imem_resp_valid && (drop_q != '0);

    assign out_valid = filled_q[head_q] && !redirect_valid;
    assign out_instr = instr_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign pop       = out_valid && out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        filled_d   = filled_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        pending_d  = pending_q;
        drop_d     = drop_q;

        if (redirect_valid) begin
            // Redirect wins over everything else this cycle.
            fetch_pc_d = redirect_target;
            filled_d   = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            pending_d  = '0;
            // Outstanding requests become discards; a response arriving now is itself
            // one of them and is consumed immediately.
            drop_d     = drop_q + DROP_W'(pending_q);
            if (imem_resp_valid && (drop_d != '0)) begin
                drop_d = drop_d - DROP_W'(1);
            end
        end else begin
            if (accept) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            end
            if (resp_fill) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PTR_W'(1);
            end else if (resp_drop) begin
                drop_d = drop_q - DROP_W'(1);
            end
            // Pop targets a filled head, never the entry being filled this cycle.
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_W'(1);
            end
            count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
            pending_d = pending_q + CNT_W'(accept) - CNT_W'(resp_fill);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            filled_q   <= filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    // Payload storage needs no reset: validity is carried entirely by filled_q.
    always_ff @(posedge clk) begin
        if (!redirect_valid) begin
            if (accept) begin
                pc_q[tail_q] <= fetch_pc_q;
            end
            if (resp_fill) begin
                instr_q[fill_q] <= imem_resp_data;
            end
        end
    end

`ifdef IFQ_ALIGN_CHECK_EN
    logic fault_q;

    // Every redirect re-evaluates the flag: misaligned sets it, aligned clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];
    assign fetch_fault         = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed self-checking bench for instruction_fetch_queue. A 64-bit instance carries the main
// scenarios; an 8-bit instance shares every input and is used for the PC wrap case. The memory
// model answers in order, one cycle after accept, unless held.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [61:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_fault;

    logic [7:0]  sm_redirect_pc;
    logic        sm_imem_req_valid;
    logic [5:0]  sm_imem_addr;
    logic        sm_out_valid;
    logic [31:0] sm_out_instr;
    logic [7:0]  sm_out_pc;
    logic        sm_fetch_fault;

    logic [61:0] mem_q [$];
    bit          mem_hold;
    bit          acc;
    logic [61:0] acc_addr;
    int          n_tests;
    int          n_fail;

    always #5 clk = ~clk;

    assign sm_redirect_pc = redirect_pc[7:0];

    instruction_fetch_queue #(
        .PC_WIDTH (64),
        .RESET_PC (64'h0),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_fault     (fetch_fault)
    );

    instruction_fetch_queue #(
        .PC_WIDTH (8),
        .RESET_PC (8'h0),
        .DEPTH    (4)
    ) dut_small (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (sm_redirect_pc),
        .imem_req_valid  (sm_imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (sm_imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (sm_out_valid),
        .out_ready       (out_ready),
        .out_instr       (sm_out_instr),
        .out_pc          (sm_out_pc),
        .fetch_fault     (sm_fetch_fault)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'h1300_0013 ^ pc[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge: present this cycle's response and note any accept.
    task automatic begin_cycle();
        if (!mem_hold && mem_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of({mem_q.pop_front(), 2'b00});
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        if (acc) mem_q.push_back(acc_addr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        check("rst_addr", imem_addr, 62'h0);
        repeat (2) @(negedge clk);
        mem_q.delete();
        mem_hold = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic expect_next(input string tag, input logic [63:0] pc);
        begin_cycle();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, instr_of(pc));
        end_cycle();
    endtask

    task automatic wait_out(input string tag, input logic [63:0] pc);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            begin_cycle();
            if (out_valid) begin
                seen = 1'b1;
                check({tag, "_pc"}, out_pc, pc);
                check({tag, "_instr"}, out_instr, instr_of(pc));
            end
            end_cycle();
        end
        check({tag, "_seen"}, {63'b0, seen}, 64'd1);
    endtask

    initial begin
        bit seen;
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready       = 1'b0;
        mem_hold        = 1'b0;
        do_reset();

        // Streaming with a 1-cycle memory: 2-cycle first latency, then one per cycle.
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        begin_cycle();
        check("a_req0", imem_req_valid, 1'b1);
        check("a_addr0", imem_addr, 62'h0);
        end_cycle();
        begin_cycle();
        check("a_lat1", out_valid, 1'b0);
        end_cycle();
        for (int k = 0; k < 6; k++) expect_next("a_stream", 64'(4 * k));

        // Leave discards pending, then reset mid-cycle: nothing may carry over.
        mem_hold       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        begin_cycle();
        end_cycle();
        redirect_valid = 1'b0;
        do_reset();
        wait_out("g_first", 64'h0);
        expect_next("g_second", 64'h4);

        // Back-pressure: full after 4 accepts, reopens the cycle after a pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            check("b_req", imem_req_valid, 1'b1);
            check("b_addr", imem_addr, 62'(i));
            end_cycle();
        end
        begin_cycle();
        check("b_full", imem_req_valid, 1'b0);
        check("b_head_valid", out_valid, 1'b1);
        check("b_head_pc", out_pc, 64'h0);
        end_cycle();
        out_ready = 1'b1;
        begin_cycle();
        check("b_pop_cycle_req", imem_req_valid, 1'b0);
        end_cycle();
        out_ready = 1'b0;
        begin_cycle();
        check("b_reopen", imem_req_valid, 1'b1);
        check("b_reopen_addr", imem_addr, 62'h4);
        check("b_new_head", out_pc, 64'h4);
        end_cycle();

        // Redirect with 3 responses outstanding.
        do_reset();
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        repeat (3) begin
            begin_cycle();
            end_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        begin_cycle();
        check("c_rd_req", imem_req_valid, 1'b0);
        check("c_rd_out", out_valid, 1'b0);
        end_cycle();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        begin_cycle();
        check("c_req", imem_req_valid, 1'b1);
        check("c_addr", imem_addr, 62'h40);
        end_cycle();
        wait_out("c_first", 64'h100);
        expect_next("c_second", 64'h104);

        // Redirect coinciding with a response and a ready head.
        do_reset();
        out_ready = 1'b0;
        repeat (2) begin
            begin_cycle();
            end_cycle();
        end
        mem_hold = 1'b1;
        repeat (2) begin
            begin_cycle();
            end_cycle();
        end
        mem_hold       = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        begin_cycle();
        check("d_out_masked", out_valid, 1'b0);
        check("d_resp_present", imem_resp_valid, 1'b1);
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        check("d_addr", imem_addr, 62'h80);
        end_cycle();
        wait_out("d_first", 64'h200);
        expect_next("d_second", 64'h204);

        // PC wrap on the 8-bit instance.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFC;
        begin_cycle();
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        check("e_req", sm_imem_req_valid, 1'b1);
        check("e_addr0", sm_imem_addr, 6'h3F);
        end_cycle();
        begin_cycle();
        check("e_addr_wrap", sm_imem_addr, 6'h00);
        end_cycle();
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            begin_cycle();
            if (sm_out_valid) begin
                seen = 1'b1;
                check("e_pc_fc", sm_out_pc, 8'hFC);
            end
            end_cycle();
        end
        check("e_seen", {63'b0, seen}, 64'd1);
        begin_cycle();
        check("e_wrap_valid", sm_out_valid, 1'b1);
        check("e_pc_00", sm_out_pc, 8'h00);
        end_cycle();

        // Misaligned redirect.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        begin_cycle();
        end_cycle();
        redirect_valid = 1'b0;
`ifdef IFQ_ALIGN_CHECK_EN
        repeat (2) begin
            begin_cycle();
            check("f_fault_set", fetch_fault, 1'b1);
            check("f_halted", imem_req_valid, 1'b0);
            end_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        begin_cycle();
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        check("f_fault_clear", fetch_fault, 1'b0);
        check("f_resume_req", imem_req_valid, 1'b1);
        check("f_resume_addr", imem_addr, 62'h80);
        end_cycle();
        wait_out("f_first", 64'h200);
`else
        begin_cycle();
        check("f_no_fault", fetch_fault, 1'b0);
        check("f_req", imem_req_valid, 1'b1);
        check("f_addr_masked", imem_addr, 62'h40);
        end_cycle();
        wait_out("f_first", 64'h100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
